// File: rtl/mult_acc_stage.sv
// Accumulate stage behind the 8x8 multiplier: sums a vector of 16-bit products and returns sum/count/overflow.
// Define MULT_ACC_SAT_EN to clamp the accumulator on overflow; by default it wraps modulo 2^ACC_W.
`timescale 1ns/1ps
module mult_acc_stage #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_product,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam int               PAD_W   = ACC_W + 1 - 16;
    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};
    localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q,     state_d;
    logic [ACC_W-1:0] acc_q,       acc_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic             ovf_q,       ovf_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_acc_q,   out_acc_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_ovf_q,   out_ovf_d;

    logic             beat_s;
    logic [ACC_W:0]   sum_s;
    logic             ovf_next_s;
    logic [ACC_W-1:0] acc_next_s;
    logic [CNT_W-1:0] count_next_s;

    // Saturating beat counter increment.
    function automatic logic [CNT_W-1:0] count_inc(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] res;
        if (cnt == CNT_MAX) begin
            res = cnt;
        end else begin
            res = cnt + CNT_ONE;
        end
        return res;
    endfunction

    // Datapath for one accepted beat: widened add, sticky carry, wrap or clamp.
    always_comb begin
        beat_s       = in_valid & in_ready_q;
        sum_s        = {1'b0, acc_q} + {{PAD_W{1'b0}}, in_product};
        ovf_next_s   = ovf_q | sum_s[ACC_W];
`ifdef MULT_ACC_SAT_EN
        // once clamped, the accumulator stays pinned for the rest of the vector
        if (ovf_next_s) begin
            acc_next_s = ACC_MAX;
        end else begin
            acc_next_s = sum_s[ACC_W-1:0];
        end
`else
        acc_next_s   = sum_s[ACC_W-1:0];
`endif
        count_next_s = count_inc(count_q);
    end

    // Control FSM and next-state values for every register.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_acc_d   = out_acc_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        case (state_q)
            ST_IDLE, ST_ACC: begin
                if (beat_s) begin
                    acc_d   = acc_next_s;
                    count_d = count_next_s;
                    ovf_d   = ovf_next_s;
                    if (in_last) begin
                        state_d     = ST_HOLD;
                        out_valid_d = 1'b1;
                        out_acc_d   = acc_next_s;
                        out_count_d = count_next_s;
                        out_ovf_d   = ovf_next_s;
                    end else begin
                        state_d = ST_ACC;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    acc_d       = ACC_ZERO;
                    count_d     = CNT_ZERO;
                    ovf_d       = 1'b0;
                    out_valid_d = 1'b0;
                    out_acc_d   = ACC_ZERO;
                    out_count_d = CNT_ZERO;
                    out_ovf_d   = 1'b0;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                acc_d       = ACC_ZERO;
                count_d     = CNT_ZERO;
                ovf_d       = 1'b0;
                out_valid_d = 1'b0;
                out_acc_d   = ACC_ZERO;
                out_count_d = CNT_ZERO;
                out_ovf_d   = 1'b0;
            end
        endcase
        in_ready_d = (state_d != ST_HOLD);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= ACC_ZERO;
            count_q     <= CNT_ZERO;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_acc_q   <= ACC_ZERO;
            out_count_q <= CNT_ZERO;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    // in_ready is forced low while reset is held so no beat is offered into a resetting stage.
    assign in_ready  = in_ready_q & rst_n;
    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mult_acc_stage.sv
// Self-checking bench for mult_acc_stage: vector-level model plus directed literal expectations.
`timescale 1ns/1ps
module tb_mult_acc_stage;

    localparam int     ACC_W   = 24;
    localparam int     CNT_W   = 8;
    localparam longint ACC_LIM = longint'(1) << ACC_W;
    localparam int     CNT_SAT = (1 << CNT_W) - 1;
`ifdef MULT_ACC_SAT_EN
    localparam longint OVF_259_ACC = 64'd16777215;
`else
    localparam longint OVF_259_ACC = 64'd64259;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_product;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    int checks = 0;
    int errors = 0;

    // vector-level reference state
    bit     m_hold = 1'b0;
    longint m_sum  = 0;
    int     m_n    = 0;
    longint e_acc  = 0;
    int     e_cnt  = 0;
    bit     e_ovf  = 1'b0;

    mult_acc_stage #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    function automatic longint exp_acc(input longint total);
`ifdef MULT_ACC_SAT_EN
        return (total >= ACC_LIM) ? ACC_LIM - 1 : total;
`else
        return total % ACC_LIM;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: accumulate whole-vector totals and derive the result once the last beat lands.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_hold <= 1'b0;
            m_sum  <= 0;
            m_n    <= 0;
        end else if (m_hold) begin
            if (out_ready) m_hold <= 1'b0;
        end else if (in_valid) begin
            if (in_last) begin
                m_hold <= 1'b1;
                e_acc  <= exp_acc(m_sum + longint'(in_product));
                e_cnt  <= (m_n + 1 > CNT_SAT) ? CNT_SAT : m_n + 1;
                e_ovf  <= (m_sum + longint'(in_product)) >= ACC_LIM;
                m_sum  <= 0;
                m_n    <= 0;
            end else begin
                m_sum <= m_sum + longint'(in_product);
                m_n   <= m_n + 1;
            end
        end
    end

    // Cycle compare against the reference.
    always @(negedge clk) begin
        chk("in_ready", in_ready, rst_n & ~m_hold);
        chk("out_valid", out_valid, m_hold);
        if (m_hold) begin
            chk("out_acc", out_acc, e_acc);
            chk("out_count", out_count, e_cnt);
            chk("out_ovf", out_ovf, e_ovf);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic beat(input logic [15:0] v, input bit last);
        in_valid   = 1'b1;
        in_product = v;
        in_last    = last;
        step();
        in_valid   = 1'b0;
        in_last    = 1'b0;
    endtask

    task automatic wait_result(input string name, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 8 && !seen; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: got out_valid=0 after 8 cycles expected 1", name);
        end
    endtask

    initial begin
        int lat;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_product = 16'd0;
        in_last    = 1'b0;
        out_ready  = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_acc", out_acc, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_out_ovf", out_ovf, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        // three-beat vector
        beat(16'd10, 1'b0);
        beat(16'd20, 1'b0);
        beat(16'd30, 1'b1);
        wait_result("t1", lat);
        chk("t1_latency", lat, 1);
        chk("t1_acc", out_acc, 60);
        chk("t1_count", out_count, 3);
        chk("t1_ovf", out_ovf, 0);

        // single-beat vector
        step();
        beat(16'd65025, 1'b1);
        wait_result("t2", lat);
        chk("t2_latency", lat, 1);
        chk("t2_acc", out_acc, 65025);
        chk("t2_count", out_count, 1);

        // backpressure in HOLD with in_valid pushing
        step();
        out_ready = 1'b0;
        beat(16'd5, 1'b0);
        beat(16'd6, 1'b1);
        wait_result("t3", lat);
        chk("t3_acc", out_acc, 11);
        step();
        in_valid   = 1'b1;
        in_product = 16'd99;
        in_last    = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("t3_bp_in_ready", in_ready, 0);
            chk("t3_bp_valid", out_valid, 1);
            chk("t3_bp_acc", out_acc, 11);
            chk("t3_bp_count", out_count, 2);
        end
        @(posedge clk);
        #2 out_ready = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_result("t3b", lat);
        chk("t3b_latency", lat, 1);
        chk("t3b_acc", out_acc, 99);
        chk("t3b_count", out_count, 1);

        // overflow: 259 x 65025
        step();
        for (int i = 0; i < 259; i++) beat(16'd65025, i == 258);
        wait_result("t4", lat);
        chk("t4_acc", out_acc, OVF_259_ACC);
        chk("t4_ovf", out_ovf, 1);
        chk("t4_count", out_count, 255);

        // boundary without overflow: 258 x 65025
        step();
        for (int i = 0; i < 258; i++) beat(16'd65025, i == 257);
        wait_result("t5", lat);
        chk("t5_acc", out_acc, 16776450);
        chk("t5_ovf", out_ovf, 0);
        chk("t5_count", out_count, 255);

        // reset mid-vector discards partial state
        step();
        beat(16'd3, 1'b0);
        beat(16'd3, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_valid", out_valid, 0);
        chk("t6_acc", out_acc, 0);
        chk("t6_count", out_count, 0);
        chk("t6_ovf", out_ovf, 0);
        beat(16'd7, 1'b1);
        wait_result("t6", lat);
        chk("t6_latency", lat, 1);
        chk("t6_acc7", out_acc, 7);
        chk("t6_count1", out_count, 1);

        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
